// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU execute stage.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned ALU_CNT_W = $clog2(ALU_WIDTH);

endpackage

// File: rtl/full_adder1.sv
// Single-bit full adder used once per RUN cycle by the serial ALU.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_alu_core.sv
// Bit-serial adder execute stage: one full adder, WIDTH RUN cycles per operation,
// registered result and flags updated only when an operation completes.
module serial_alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] AMod,
    input  logic [WIDTH-1:0] BMod,
    input  logic             Cin,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;

    full_adder1 u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    assign acc_next = {fa_sum, acc[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath, handshake and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            R     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b1;
            N     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= AMod;
                        b_sh  <= BMod;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_next;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    // carry is still the carry into the MSB on the final bit
                    if (last_bit) begin
                        R    <= acc_next;
                        Cout <= fa_cout;
                        V    <= carry ^ fa_cout;
                        Z    <= (acc_next == '0);
                        N    <= fa_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_core.sv
// Directed self-checking bench for serial_alu_core at WIDTH=4.
module tb_serial_alu_core;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] AMod;
    logic [3:0] BMod;
    logic       Cin;
    logic [3:0] R;
    logic       Cout;
    logic       V;
    logic       Z;
    logic       N;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    serial_alu_core #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .AMod  (AMod),
        .BMod  (BMod),
        .Cin   (Cin),
        .R     (R),
        .Cout  (Cout),
        .V     (V),
        .Z     (Z),
        .N     (N),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, return edges from the start edge to done (-1 on timeout).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                          output int lat);
        @(posedge clk);
        @(negedge clk);
        AMod  = a;
        BMod  = b;
        Cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        AMod  = 4'h0;
        BMod  = 4'h0;
        Cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (R !== 4'b0000 || Cout !== 1'b0 || V !== 1'b0 || Z !== 1'b1 ||
            N !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: R=%b C=%b V=%b Z=%b N=%b busy=%b done=%b, want R=0000 C=0 V=0 Z=1 N=0 busy=0 done=0",
                     R, Cout, V, Z, N, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_add;
        int         lat;
        run_op(4'b0101, 4'b0011, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency: got %0d, want 4", lat);
        end
        checks++;
        if (R !== 4'b1000 || Cout !== 1'b0 || V !== 1'b1 || N !== 1'b1 || Z !== 1'b0) begin
            errors++;
            $display("FAIL add_5_3: R=%b C=%b V=%b Z=%b N=%b, want R=1000 C=0 V=1 Z=0 N=1",
                     R, Cout, V, Z, N);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || R !== 4'b1000 || V !== 1'b1) begin
            errors++;
            $display("FAIL add_hold: done=%b busy=%b R=%b V=%b, want done=0 busy=0 R=1000 V=1",
                     done, busy, R, V);
        end
    endtask

    task automatic test_sub;
        int lat;
        run_op(4'b0111, 4'b1000, 1'b1, lat);
        checks++;
        if (lat !== 4 || R !== 4'b0000 || Cout !== 1'b1 || Z !== 1'b1 ||
            V !== 1'b0 || N !== 1'b0) begin
            errors++;
            $display("FAIL sub_7_7: lat=%0d R=%b C=%b V=%b Z=%b N=%b, want lat=4 R=0000 C=1 V=0 Z=1 N=0",
                     lat, R, Cout, V, Z, N);
        end
    endtask

    task automatic test_wrap;
        int lat;
        run_op(4'b1111, 4'b0001, 1'b0, lat);
        checks++;
        if (lat !== 4 || R !== 4'b0000 || Cout !== 1'b1 || Z !== 1'b1 || V !== 1'b0) begin
            errors++;
            $display("FAIL wrap_f_1: lat=%0d R=%b C=%b V=%b Z=%b, want lat=4 R=0000 C=1 V=0 Z=1",
                     lat, R, Cout, V, Z);
        end
        run_op(4'b1000, 4'b1000, 1'b0, lat);
        checks++;
        if (lat !== 4 || R !== 4'b0000 || Cout !== 1'b1 || V !== 1'b1 ||
            Z !== 1'b1 || N !== 1'b0) begin
            errors++;
            $display("FAIL wrap_8_8: lat=%0d R=%b C=%b V=%b Z=%b N=%b, want lat=4 R=0000 C=1 V=1 Z=1 N=0",
                     lat, R, Cout, V, Z, N);
        end
    endtask

    // start held high: ops accepted at k, k+6, k+12; operands changed mid-RUN.
    task automatic test_back_to_back;
        logic exp_done;
        logic exp_busy;
        @(posedge clk);
        @(negedge clk);
        AMod  = 4'd1;
        BMod  = 4'd2;
        Cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy_start: busy=%b, want 1", busy);
        end
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            exp_done = (i == 4 || i == 10 || i == 16);
            exp_busy = !(i == 5 || i == 11);
            checks++;
            if (done !== exp_done || busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b_handshake cycle %0d: done=%b busy=%b, want done=%b busy=%b",
                         i, done, busy, exp_done, exp_busy);
            end
            if (i == 4) begin
                checks++;
                if (R !== 4'b0011) begin
                    errors++;
                    $display("FAIL b2b_op1: R=%b, want 0011", R);
                end
            end
            if (i == 10) begin
                checks++;
                if (R !== 4'b1001 || V !== 1'b1 || N !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_op2: R=%b V=%b N=%b, want 1001 1 1", R, V, N);
                end
            end
            if (i == 16) begin
                checks++;
                if (R !== 4'b1100 || Cout !== 1'b0 || V !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_op3: R=%b C=%b V=%b, want 1100 0 1", R, Cout, V);
                end
            end
            if (i == 2) begin
                AMod = 4'd4;
                BMod = 4'd5;
            end
            if (i == 8) begin
                AMod = 4'd6;
                BMod = 4'd6;
            end
            if (i == 12) start = 1'b0;
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        @(posedge clk);
        @(negedge clk);
        AMod  = 4'd1;
        BMod  = 4'd1;
        Cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || R !== 4'b0000 || Z !== 1'b1 ||
            Cout !== 1'b0 || V !== 1'b0 || N !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b R=%b Z=%b C=%b V=%b N=%b, want 0 0 0000 1 0 0 0",
                     busy, done, R, Z, Cout, V, N);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done cycle %0d: done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
        run_op(4'b0010, 4'b0011, 1'b0, lat);
        checks++;
        if (lat !== 4 || R !== 4'b0101 || Z !== 1'b0 || V !== 1'b0 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_fresh: lat=%0d R=%b Z=%b V=%b C=%b, want lat=4 R=0101 Z=0 V=0 C=0",
                     lat, R, Z, V, Cout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
